// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: timer states, clamp limits
// and the width helper used to size bit counters.
package uart_rx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   // Below 4 there is no room for three sample edges around the bit midpoint.
   localparam int MIN_PRESCALE   = 4;
   // A frame must hold at least a start bit plus one more bit.
   localparam int MIN_FRAME_BITS = 2;

   // Width needed to hold a bit index/count of 0..maxBits.
   function automatic int bitCntWidth(input int maxBits);
      return $clog2(maxBits + 1);
   endfunction

endpackage

// File: rtl/rx_frame_timer_if.sv
// Bus between the RX controller / sampler side and the frame timer.
// The controller (master) requests a frame and supplies its timing;
// the timer (slave) returns counters and sampling strobes.
interface rx_frame_timer_if
   import uart_rx_pkg::*;
#(
   parameter int MAX_FRAME_BITS = 12,
   parameter int PRESCALE_W     = 6
);

   localparam int BCW = bitCntWidth(MAX_FRAME_BITS);

   logic                  enable;
   logic [PRESCALE_W-1:0] Prescale;
   logic [BCW-1:0]        frame_bits;
   logic [PRESCALE_W-1:0] edge_cnt;
   logic [BCW-1:0]        bit_cnt;
   logic                  busy;
   logic                  sample_stb;
   logic                  sample_last;
   logic                  bit_done;
   logic                  frame_done;

   modport master (
      output enable, Prescale, frame_bits,
      input  edge_cnt, bit_cnt, busy, sample_stb, sample_last, bit_done, frame_done
   );

   modport slave (
      input  enable, Prescale, frame_bits,
      output edge_cnt, bit_cnt, busy, sample_stb, sample_last, bit_done, frame_done
   );

endinterface

// File: rtl/rx_frame_timer.sv
// Oversampling frame timer for the UART receiver. Counts oversampling edges
// and bit positions over a whole frame, latching prescale and frame length at
// frame start, and decodes the 3-sample majority strobes plus bit/frame done.
module rx_frame_timer
   import uart_rx_pkg::*;
#(
   parameter int MAX_FRAME_BITS = 12,
   parameter int PRESCALE_W     = 6
) (
   input  logic              CLK,
   input  logic              RST,
   rx_frame_timer_if.slave   bus
);

   localparam int BCW = bitCntWidth(MAX_FRAME_BITS);

   state_t                state_q;
   logic [PRESCALE_W-1:0] edge_q;
   logic [BCW-1:0]        bit_q;
   logic [PRESCALE_W-1:0] ps_q;
   logic [BCW-1:0]        fb_q;

   logic [PRESCALE_W-1:0] ps_d;
   logic [BCW-1:0]        fb_d;
   logic [PRESCALE_W-1:0] psLast;
   logic [BCW-1:0]        fbLast;
   logic [PRESCALE_W-1:0] mid;
   logic [PRESCALE_W-1:0] midLo;
   logic [PRESCALE_W-1:0] midHi;
   logic                  inRun;
   logic                  lastEdge;
   logic                  lastBit;

   // Clamp the requested timing into the supported range; only used at frame start.
   always_comb begin
      ps_d = bus.Prescale;
      if (bus.Prescale < PRESCALE_W'(MIN_PRESCALE)) begin
         ps_d = PRESCALE_W'(MIN_PRESCALE);
      end
      fb_d = bus.frame_bits;
      if (bus.frame_bits < BCW'(MIN_FRAME_BITS)) begin
         fb_d = BCW'(MIN_FRAME_BITS);
      end else if (bus.frame_bits > BCW'(MAX_FRAME_BITS)) begin
         fb_d = BCW'(MAX_FRAME_BITS);
      end
   end

   assign psLast   = ps_q - 1'b1;
   assign fbLast   = fb_q - 1'b1;
   assign inRun    = (state_q == ST_RUN);
   assign lastEdge = (edge_q == psLast);
   assign lastBit  = (bit_q == fbLast);

   // FSM and counters: IDLE waits for enable, RUN walks edges/bits, HOLD parks
   // until enable drops so each frame needs a fresh enable request.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         edge_q  <= '0;
         bit_q   <= '0;
         ps_q    <= '0;
         fb_q    <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               edge_q <= '0;
               bit_q  <= '0;
               if (bus.enable) begin
                  state_q <= ST_RUN;
                  ps_q    <= ps_d;
                  fb_q    <= fb_d;
               end
            end
            ST_RUN: begin
               if (!bus.enable) begin
                  state_q <= ST_IDLE;
                  edge_q  <= '0;
                  bit_q   <= '0;
               end else if (lastEdge) begin
                  edge_q <= '0;
                  if (lastBit) begin
                     state_q <= ST_HOLD;
                     bit_q   <= '0;
                  end else begin
                     bit_q <= bit_q + 1'b1;
                  end
               end else begin
                  edge_q <= edge_q + 1'b1;
               end
            end
            ST_HOLD: begin
               edge_q <= '0;
               bit_q  <= '0;
               if (!bus.enable) begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               edge_q  <= '0;
               bit_q   <= '0;
            end
         endcase
      end
   end

   // Strobes decode from registered state only, so they line up with the
   // counters and never see the inputs combinationally.
   assign mid   = ps_q >> 1;
   assign midLo = mid - 1'b1;
   assign midHi = mid + 1'b1;

   assign bus.edge_cnt    = edge_q;
   assign bus.bit_cnt     = bit_q;
   assign bus.busy        = inRun;
   assign bus.sample_stb  = inRun && (edge_q >= midLo) && (edge_q <= midHi);
   assign bus.sample_last = inRun && (edge_q == midHi);
   assign bus.bit_done    = inRun && lastEdge;
   assign bus.frame_done  = inRun && lastEdge && lastBit;

endmodule

// File: tb/tb_rx_frame_timer.sv
// Self-checking bench for rx_frame_timer. A frame-time model predicts every
// output per cycle; predictions are queued as stimulus is driven and popped
// when the DUT outputs settle after the clock edge.
module tb_rx_frame_timer;

   localparam int PW  = 6;
   localparam int MFB = 12;
   localparam int BW  = 4;

   logic CLK = 1'b0;
   logic RST;

   always #5 CLK = ~CLK;

   rx_frame_timer_if #(.MAX_FRAME_BITS(MFB), .PRESCALE_W(PW)) bus ();

   rx_frame_timer #(.MAX_FRAME_BITS(MFB), .PRESCALE_W(PW)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   int checks = 0;
   int passes = 0;
   int cyc    = 0;

   logic [14:0] expQ[$];

   int mState = 0;
   int mT     = 0;
   int mPs    = 0;
   int mFb    = 0;

   int runCount  = 0;
   int stbCount  = 0;
   int lastCount = 0;
   int bdCount   = 0;
   int fdCount   = 0;

   // Single comparison point: count it and report any difference.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Frame-time model: one elapsed-cycle counter per frame, edge/bit derived.
   task automatic modelStep(input logic r, input logic e, input int ps, input int fb);
      if (r) begin
         mState = 0; mT = 0; mPs = 0; mFb = 0;
      end else begin
         case (mState)
            0: if (e) begin
                  mState = 1; mT = 0;
                  mPs = (ps < 4) ? 4 : ps;
                  mFb = (fb < 2) ? 2 : ((fb > MFB) ? MFB : fb);
               end
            1: if (!e) begin
                  mState = 0; mT = 0;
               end else if (mT == mPs * mFb - 1) begin
                  mState = 2; mT = 0;
               end else begin
                  mT++;
               end
            default: begin
               mT = 0;
               if (!e) mState = 0;
            end
         endcase
      end
   endtask

   function automatic logic [14:0] modelOut();
      int edgeV, bitV, midV;
      logic stb, lst, bd, fd;
      if (mState != 1) return '0;
      edgeV = mT % mPs;
      bitV  = mT / mPs;
      midV  = mPs / 2;
      stb   = (edgeV >= midV - 1) && (edgeV <= midV + 1);
      lst   = (edgeV == midV + 1);
      bd    = (edgeV == mPs - 1);
      fd    = (mT == mPs * mFb - 1);
      return {PW'(edgeV), BW'(bitV), 1'b1, stb, lst, bd, fd};
   endfunction

   task automatic resetStats();
      runCount = 0; stbCount = 0; lastCount = 0; bdCount = 0; fdCount = 0;
   endtask

   // Drive one cycle of inputs, predict, clock, then compare the settled outputs.
   task automatic applyStimulus(input logic r, input logic e, input int ps, input int fb);
      logic [14:0] obs, exp;
      logic [PW-1:0] psV;
      logic [BW-1:0] fbV;
      psV = ps[PW-1:0];
      fbV = fb[BW-1:0];
      RST            = r;
      bus.enable     = e;
      bus.Prescale   = psV;
      bus.frame_bits = fbV;
      modelStep(r, e, int'(psV), int'(fbV));
      expQ.push_back(modelOut());
      @(posedge CLK);
      #1;
      cyc++;
      obs = {bus.edge_cnt, bus.bit_cnt, bus.busy, bus.sample_stb,
             bus.sample_last, bus.bit_done, bus.frame_done};
      runCount  += int'(bus.busy);
      stbCount  += int'(bus.sample_stb);
      lastCount += int'(bus.sample_last);
      bdCount   += int'(bus.bit_done);
      fdCount   += int'(bus.frame_done);
      exp = expQ.pop_front();
      checkOutput($sformatf("cyc%0d_outputs", cyc), 32'(obs), 32'(exp));
   endtask

   task automatic runFor(input int n, input logic r, input logic e, input int ps, input int fb);
      for (int i = 0; i < n; i++) applyStimulus(r, e, ps, fb);
   endtask

   initial begin
      RST = 1'b1; bus.enable = 1'b0; bus.Prescale = '0; bus.frame_bits = '0;

      // Reset state, even with enable requested.
      runFor(2, 1'b1, 1'b0, 8, 10);
      applyStimulus(1'b1, 1'b1, 8, 10);
      runFor(2, 1'b0, 1'b0, 8, 10);

      // Prescale 8, 10 bits: 80 RUN cycles, then HOLD while enable stays high.
      resetStats();
      runFor(84, 1'b0, 1'b1, 8, 10);
      checkOutput("p8_run_cycles", 32'(runCount), 32'd80);
      checkOutput("p8_sample_stb", 32'(stbCount), 32'd30);
      checkOutput("p8_sample_last", 32'(lastCount), 32'd10);
      checkOutput("p8_bit_done", 32'(bdCount), 32'd10);
      checkOutput("p8_frame_done", 32'(fdCount), 32'd1);
      applyStimulus(1'b0, 1'b0, 8, 10);

      // Both clamps low: Prescale 2 -> 4, frame_bits 0 -> 2.
      resetStats();
      runFor(10, 1'b0, 1'b1, 2, 0);
      checkOutput("clamp_lo_run_cycles", 32'(runCount), 32'd8);
      checkOutput("clamp_lo_frame_done", 32'(fdCount), 32'd1);
      applyStimulus(1'b0, 1'b0, 2, 0);

      // Prescale 16, 12 bits, Prescale changed mid-frame must be ignored.
      resetStats();
      runFor(20, 1'b0, 1'b1, 16, 12);
      runFor(174, 1'b0, 1'b1, 5, 12);
      checkOutput("p16_run_cycles", 32'(runCount), 32'd192);
      checkOutput("p16_bit_done", 32'(bdCount), 32'd12);
      applyStimulus(1'b0, 1'b0, 5, 12);

      // Frame length above the maximum clamps to 12 bits.
      resetStats();
      runFor(50, 1'b0, 1'b1, 4, 15);
      checkOutput("clamp_hi_run_cycles", 32'(runCount), 32'd48);
      applyStimulus(1'b0, 1'b0, 4, 15);

      // Abort at bit 4, edge 7: no frame_done, then a fresh frame from 0.
      resetStats();
      runFor(40, 1'b0, 1'b1, 8, 10);
      applyStimulus(1'b0, 1'b0, 8, 10);
      checkOutput("abort_frame_done", 32'(fdCount), 32'd0);
      checkOutput("abort_bit_done", 32'(bdCount), 32'd5);
      runFor(10, 1'b0, 1'b1, 8, 10);
      applyStimulus(1'b0, 1'b0, 8, 10);

      // Reset mid-frame with enable high, then restart from edge 0.
      runFor(20, 1'b0, 1'b1, 8, 10);
      runFor(2, 1'b1, 1'b1, 8, 10);
      runFor(12, 1'b0, 1'b1, 8, 10);
      applyStimulus(1'b0, 1'b0, 8, 10);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/rx_frame_timer.md
# rx_frame_timer

Parametrised oversampling timer for the UART receive path, succeeding the fixed 8-bit edge/bit counter. It counts oversampling edges and bit positions for a whole frame of configurable length, latches prescale and frame length per frame, and emits the sampling strobes for 3-sample majority voting. It also emits bit-done and frame-done pulses. It sits between the RX controller FSM (which drives `enable`) and the data sampler, deserializer, parity and stop checkers.

## Interface
- `MAX_FRAME_BITS`, default 12: largest supported frame length (start + data + parity + stops).
- `PRESCALE_W`, default 6: width of the prescale input and edge counter.
- `CLK` input, 1 bit: clock, all logic on rising edge.
- `RST` input, 1 bit: reset, synchronous active-high.
- `enable` input, 1 bit: run request from the RX controller. Deassertion aborts the frame.
- `Prescale` input, `PRESCALE_W` bits: oversampling ratio. Legal range 4..2^PRESCALE_W-1; values below 4 are treated as 4.
- `frame_bits` input, `$clog2(MAX_FRAME_BITS+1)` bits: bits per frame. Legal range 2..`MAX_FRAME_BITS`; 0 or 1 is treated as 2, and values above the maximum are treated as the maximum.
- `edge_cnt` output, `PRESCALE_W` bits: edge index within the current bit.
- `bit_cnt` output, `$clog2(MAX_FRAME_BITS+1)` bits: index of the current bit within the frame.
- `busy` output, 1 bit: state is RUN.
- `sample_stb` output, 1 bit: high on each of the 3 sample edges.
- `sample_last` output, 1 bit: high on the third sample edge (majority evaluate point).
- `bit_done` output, 1 bit: high on the last edge of each bit.
- `frame_done` output, 1 bit: high on the last edge of the last bit.

## Operation
- States: IDLE, RUN, HOLD. All outputs are 0 in reset and in IDLE.
- Prescale clamp: `ps_eff = max(Prescale, 4)`.
- Frame-length clamp: `fb_eff` = `frame_bits` clamped to 2..`MAX_FRAME_BITS`.
- IDLE -> RUN when `enable` = 1. On that edge: `ps_q <= ps_eff`, `fb_q <= fb_eff`, `edge_cnt <= 0`, `bit_cnt <= 0`.
- Inputs are sampled only on the IDLE->RUN edge. Changes mid-frame are ignored.
- RUN, per cycle:
  - `edge_cnt` increments.
  - When `edge_cnt == ps_q-1`: `edge_cnt` wraps to 0 and `bit_cnt` increments.
  - If also `bit_cnt == fb_q-1`: go to HOLD instead.
- Midpoint: `mid = ps_q >> 1`. `sample_stb` is high in RUN when `edge_cnt` is in {mid-1, mid, mid+1}. `sample_last` is high when `edge_cnt == mid+1`.
- `bit_done` is high in RUN when `edge_cnt == ps_q-1`. `frame_done = bit_done & (bit_cnt == fb_q-1)`.
- HOLD: counters are cleared to 0 and all strobes are 0. HOLD -> IDLE when `enable` = 0. A new frame therefore needs an `enable` low-then-high.
- `enable` = 0 in RUN: abort. Next state is IDLE, counters are cleared, and no `frame_done` is issued, even on what would have been the last edge.
- `RST` has priority over everything, in any state. Next state is IDLE and all registers, including `ps_q` and `fb_q`, are cleared.
- Arithmetic:
  - Counters are unsigned.
  - `edge_cnt` never exceeds `ps_q-1`.
  - `bit_cnt` never exceeds `fb_q-1`.
  - `mid+1 <= ps_q-1` is guaranteed by the min-4 clamp.

## Timing
- `edge_cnt`, `bit_cnt` and `busy` are registered.
- `sample_stb`, `sample_last`, `bit_done` and `frame_done` are decoded combinationally from the registered state and counters, so they are valid in the same cycle as the matching count. There are no input-to-output combinational paths.
- A frame lasts `ps_q*fb_q` cycles in RUN. `busy` rises one cycle after `enable` is first seen high in IDLE.
- `frame_done` is a single-cycle pulse in the last RUN cycle. The next cycle is HOLD.
- There are exactly 3 `sample_stb` pulses and 1 `bit_done` pulse per bit.

## Structure
- Shared package `uart_rx_pkg`:
  - State enum (IDLE/RUN/HOLD).
  - Constants `MIN_PRESCALE = 4` and `MIN_FRAME_BITS = 2`.
  - Bit-count width function.
- Single module with no sub-modules. Strobe decode lives in the same file.

## Test plan
- Prescale = 8, frame_bits = 10, enable held: 80 RUN cycles. `sample_stb` at edge_cnt 3, 4, 5 of every bit; `sample_last` at 5; 10 `bit_done`; `frame_done` with bit_cnt = 9; then HOLD, and `busy` = 0.
- Prescale = 2 (clamped to 4), frame_bits = 0 (clamped to 2): 8-cycle frame, samples at edge_cnt 1, 2, 3, `frame_done` at cycle 8.
- Prescale = 16, frame_bits = 12: change Prescale to 5 mid-frame -> timing stays 16 per bit, total 192 cycles.
- Deassert `enable` at bit 4, edge 7 of a Prescale = 8 frame: IDLE next cycle, counters 0, no `frame_done`. A new `enable` starts a fresh frame from 0.
- Assert `RST` mid-frame with `enable` high: all outputs 0 next cycle. After `RST` drops with `enable` still high, a new frame starts from edge 0.
- Hold `enable` high after `frame_done`: stays in HOLD with no strobes. Drop for 1 cycle, then raise -> next frame starts.
